seq_detect_moore_param: RTL and testbench

Parametrised Moore-type serial bit-pattern detector. It is the generalised successor of the fixed 1101 non-overlapping detector FSM. It adds any pattern up to 16 bits, a runtime overlap/non-overlap mode, a sample enable, a synchronous clear and a saturating match counter. It sits on a 1-bit serial input stream and flags each complete pattern occurrence to downstream control logic.

---
 rtl/seq_detect_pkg.sv | 38 +++
 rtl/seq_detect_moore_param_sat_counter.sv | 31 +++
 rtl/seq_detect_moore_param.sv | 74 +++++++
 tb/tb_seq_detect_moore_param.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared constants and elaboration-time helpers for serial pattern detectors.
// next_state() is the KMP transition used to build the per-state lookup tables.
package seq_detect_pkg;

  localparam int unsigned MAX_SEQ_LEN = 16;

  function automatic int unsigned state_width(input int unsigned len);
    return $clog2(len + 1);
  endfunction

  // Longest pattern prefix that is a suffix of (prefix_k followed by b).
  // When k == len this gives the overlapping transition out of DETECT.
  function automatic int unsigned next_state(input logic [MAX_SEQ_LEN-1:0] seq,
                                             input int unsigned len,
                                             input int unsigned k,
                                             input logic b);
    logic [MAX_SEQ_LEN:0] s;
    int unsigned n;
    int unsigned jmax;
    logic ok;
    s = '0;
    for (int unsigned i = 0; i < k; i++) begin
      s[i] = seq[len-1-i];
    end
    s[k] = b;
    n = k + 1;
    jmax = (n > len) ? len : n;
    for (int j = int'(jmax); j >= 1; j--) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (seq[int'(len)-1-i] != s[int'(n)-j+i]) ok = 1'b0;
      end
      if (ok) return j;
    end
    return 0;
  endfunction

endpackage

// File: rtl/seq_detect_moore_param_sat_counter.sv
// Saturating up-counter with async active-low reset and synchronous clear.
// Clear wins over a simultaneous increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/seq_detect_moore_param.sv
// Parametrised Moore serial pattern detector with runtime overlap mode,
// sample enable, synchronous clear and a saturating match counter.
module seq_detect_moore_param
  import seq_detect_pkg::*;
#(
  parameter int unsigned                 SEQ_LEN = 4,
  parameter logic [MAX_SEQ_LEN-1:0]      SEQ     = 16'b1101,
  parameter int unsigned                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             overlap,
  input  logic             in,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned SW    = state_width(SEQ_LEN);
  localparam int unsigned NumSt = 2 ** SW;
  localparam logic [SW-1:0] DetSt = SW'(SEQ_LEN);

  logic [SW-1:0] state_q, state_d;
  logic [SW-1:0] nxt0 [NumSt];
  logic [SW-1:0] nxt1 [NumSt];
  logic          hit;

  // Row SEQ_LEN holds the overlapping exit from DETECT; unreachable rows go to 0.
  for (genvar k = 0; k < NumSt; k++) begin : g_tbl
    if (k <= SEQ_LEN) begin : g_live
      localparam logic [SW-1:0] N0 = SW'(next_state(SEQ, SEQ_LEN, k, 1'b0));
      localparam logic [SW-1:0] N1 = SW'(next_state(SEQ, SEQ_LEN, k, 1'b1));
      assign nxt0[k] = N0;
      assign nxt1[k] = N1;
    end else begin : g_dead
      assign nxt0[k] = '0;
      assign nxt1[k] = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    if (clr) begin
      state_d = '0;
    end else if (en) begin
      if ((state_q == DetSt) && !overlap) begin
        state_d = in ? nxt1[0] : nxt0[0];
      end else begin
        state_d = in ? nxt1[state_q] : nxt0[state_q];
      end
      hit = (state_d == DetSt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= '0;
    else      state_q <= state_d;
  end

  assign out = (state_q == DetSt);

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (hit),
    .q   (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Directed bench: three detector configurations share one stimulus stream;
// each is checked only in phases that start from its own clear.
module tb_seq_detect_moore_param;

  logic clk, rst, en, clr, overlap, in;
  logic       out_a, out_b, out_c;
  logic [7:0] cnt_a, cnt_c;
  logic [2:0] cnt_b;

  int checks = 0;
  int errors = 0;

  seq_detect_moore_param u_a (
    .clk (clk), .rst (rst), .en (en), .clr (clr), .overlap (overlap), .in (in),
    .out (out_a), .match_cnt (cnt_a)
  );

  seq_detect_moore_param #(.SEQ_LEN(4), .SEQ(16'b1111), .CNT_W(3)) u_b (
    .clk (clk), .rst (rst), .en (en), .clr (clr), .overlap (overlap), .in (in),
    .out (out_b), .match_cnt (cnt_b)
  );

  seq_detect_moore_param #(.SEQ_LEN(5), .SEQ(16'b10010), .CNT_W(8)) u_c (
    .clk (clk), .rst (rst), .en (en), .clr (clr), .overlap (overlap), .in (in),
    .out (out_c), .match_cnt (cnt_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       en;
    logic       clr;
    logic       ov;
    logic       in;
    logic       exp_out;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, c, o, d, eo, input logic [7:0] ec);
    vec_t v;
    v.en = e; v.clr = c; v.ov = o; v.in = d; v.exp_out = eo; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic step(input logic e, c, o, d);
    @(negedge clk);
    en = e; clr = c; overlap = o; in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; overlap = 1'b0; in = 1'b0;
    #12;
    chk("reset_out_a", 32'(out_a), 0);
    chk("reset_cnt_a", 32'(cnt_a), 0);
    chk("reset_out_b", 32'(out_b), 0);
    chk("reset_cnt_c", 32'(cnt_c), 0);
    @(negedge clk);
    rst = 1'b1;

    // 1101 overlap on, then overlap off on the same stream
    vecs.push_back(mk(1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 1));
    vecs.push_back(mk(1, 0, 1, 1, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 1, 1, 2));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1));
    // walk to a detection, rebuild 110, then clear on the edge that would re-detect
    vecs.push_back(mk(1, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 2));
    vecs.push_back(mk(1, 0, 0, 1, 0, 2));
    vecs.push_back(mk(1, 0, 0, 1, 0, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].clr, vecs[i].ov, vecs[i].in);
      chk($sformatf("vec%0d_out", i), 32'(out_a), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d_cnt", i), 32'(cnt_a), 32'(vecs[i].exp_cnt));
    end

    // Enable gating: en low for 3 cycles mid-pattern and after a detection
    step(1, 1, 0, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1'($urandom_range(0, 1)));
      chk("engate_hold_out", 32'(out_a), 0);
    end
    step(1, 0, 0, 0);
    chk("engate_bit3_out", 32'(out_a), 0);
    step(1, 0, 0, 1);
    chk("engate_det_out", 32'(out_a), 1);
    chk("engate_det_cnt", 32'(cnt_a), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1'($urandom_range(0, 1)));
      chk("engate_det_hold_out", 32'(out_a), 1);
      chk("engate_det_hold_cnt", 32'(cnt_a), 1);
    end
    step(1, 0, 0, 1);
    chk("engate_leave_out", 32'(out_a), 0);

    // Async reset between edges while in DETECT
    step(1, 1, 0, 0);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    chk("prerst_out", 32'(out_a), 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_out", 32'(out_a), 0);
    chk("midrst_cnt", 32'(cnt_a), 0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    chk("postrst_b3_out", 32'(out_a), 0);
    step(1, 0, 0, 1);
    chk("postrst_det_out", 32'(out_a), 1);
    chk("postrst_det_cnt", 32'(cnt_a), 1);
    step(1, 0, 0, 0);
    chk("postrst_pulse_end", 32'(out_a), 0);

    // 1111 with 3-bit counter: DETECT->DETECT and saturation at 7
    step(1, 1, 1, 1);
    for (int n = 1; n <= 12; n++) begin
      int ec;
      ec = (n < 4) ? 0 : ((n - 3 > 7) ? 7 : n - 3);
      step(1, 0, 1, 1);
      chk($sformatf("sat_n%0d_out", n), 32'(out_b), (n >= 4) ? 1 : 0);
      chk($sformatf("sat_n%0d_cnt", n), 32'(cnt_b), 32'(ec));
    end
    step(1, 1, 1, 1);
    chk("sat_clr_out", 32'(out_b), 0);
    chk("sat_clr_cnt", 32'(cnt_b), 0);
    step(1, 0, 1, 1);
    chk("sat_after_clr_out", 32'(out_b), 0);

    // 10010 overlap on: border "10" gives detections after bits 5 and 8
    step(1, 1, 1, 0);
    begin
      logic [7:0] bits;
      logic [7:0] eo;
      int ec;
      bits = 8'b1001_0010;
      eo   = 8'b0000_1001;
      ec   = 0;
      for (int i = 0; i < 8; i++) begin
        step(1, 0, 1, bits[7-i]);
        if (eo[7-i]) ec++;
        chk($sformatf("p10010_b%0d_out", i + 1), 32'(out_c), 32'(eo[7-i]));
        chk($sformatf("p10010_b%0d_cnt", i + 1), 32'(cnt_c), 32'(ec));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
